// File: rtl/scr1_memif_pkg.sv
// Core-side memory interface types: command, access width and response codes
// shared by the instruction and data ports.
`ifndef SCR1_IMEM_AWIDTH
`define SCR1_IMEM_AWIDTH 32
`endif

package scr1_memif_pkg;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

endpackage

// File: rtl/scr1_tcm_pkg.sv
// TCM-local types: port id, response pipeline entry and write-lane helpers.
package scr1_tcm_pkg;
  import scr1_memif_pkg::*;

  typedef enum logic {
    TCM_PORT_IMEM = 1'b0,
    TCM_PORT_DMEM = 1'b1
  } tcm_port_e;

  typedef struct packed {
    logic      valid;
    tcm_port_e port;
    logic      err;
    logic [1:0] offset;
  } tcm_pipe_entry_s;

  // Byte enables for a store of the given width at the given byte offset.
  function automatic logic [3:0] tcm_byte_en(input type_scr1_mem_width_e width,
                                             input logic [1:0] offset);
    logic [3:0] be;
    case (width)
      SCR1_MEM_WIDTH_BYTE:  be = 4'b0001 << offset;
      SCR1_MEM_WIDTH_HWORD: be = 4'b0011 << {offset[1], 1'b0};
      default:              be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data arrives LSB-aligned; replicate it so every enabled lane sees it.
  function automatic logic [31:0] tcm_wdata_rep(input type_scr1_mem_width_e width,
                                                input logic [31:0] wdata);
    logic [31:0] rep;
    case (width)
      SCR1_MEM_WIDTH_BYTE:  rep = {4{wdata[7:0]}};
      SCR1_MEM_WIDTH_HWORD: rep = {2{wdata[15:0]}};
      default:              rep = wdata;
    endcase
    return rep;
  endfunction

endpackage

// File: rtl/scr1_sp_memory.sv
// Single-port 32-bit word memory with byte write enables and a registered,
// read-first output (a read in the same cycle as a write sees the old word).
module scr1_sp_memory #(
  parameter int DEPTH = 16384,
  parameter int AW    = 14
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_reg [DEPTH];
  logic [31:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) begin
          mem_reg[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
      rdata_reg <= mem_reg[addr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/scr1_tcm_sp.sv
// Tightly-coupled memory shared by the fetch and data ports over one
// single-port RAM, with round-robin arbitration and a fixed-latency response.
`ifndef SCR1_IMEM_AWIDTH
`define SCR1_IMEM_AWIDTH 32
`endif

module scr1_tcm_sp
  import scr1_memif_pkg::*;
  import scr1_tcm_pkg::*;
#(
  parameter logic [`SCR1_IMEM_AWIDTH-1:0] SCR1_TCM_SIZE    = `SCR1_IMEM_AWIDTH'h00010000,
  parameter int                           SCR1_TCM_LATENCY = 1,
  parameter bit                           SCR1_TCM_ERR_EN  = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          imem_req,
  output logic                          imem_req_ack,
  input  logic [`SCR1_IMEM_AWIDTH-1:0]  imem_addr,
  output logic [31:0]                   imem_rdata,
  output type_scr1_mem_resp_e           imem_resp,
  input  logic                          dmem_req,
  output logic                          dmem_req_ack,
  input  type_scr1_mem_cmd_e            dmem_cmd,
  input  type_scr1_mem_width_e          dmem_width,
  input  logic [31:0]                   dmem_addr,
  input  logic [31:0]                   dmem_wdata,
  output logic [31:0]                   dmem_rdata,
  output type_scr1_mem_resp_e           dmem_resp
);

  localparam int TCM_AW = $clog2(SCR1_TCM_SIZE);
  localparam int WAW    = TCM_AW - 2;
  localparam int WORDS  = int'(SCR1_TCM_SIZE >> 2);

  tcm_port_e       last_grant_reg;
  tcm_pipe_entry_s pipe_reg [SCR1_TCM_LATENCY];
  tcm_pipe_entry_s entry_next;
  tcm_pipe_entry_s head;

  logic            imem_grant;
  logic            dmem_grant;
  logic            accept;
  logic            imem_err;
  logic            dmem_err;
  logic            dmem_align_err;
  logic            dmem_write;

  logic [WAW-1:0]  mem_addr;
  logic [3:0]      mem_we;
  logic [31:0]     mem_wdata;
  logic [31:0]     mem_rdata;
  logic [31:0]     resp_data;

  // A contested cycle goes to whichever port did not win the previous grant.
  always_comb begin
    imem_grant = 1'b0;
    dmem_grant = 1'b0;
    if (rst_n) begin
      if (imem_req && dmem_req) begin
        dmem_grant = (last_grant_reg == TCM_PORT_IMEM);
        imem_grant = ~dmem_grant;
      end else begin
        imem_grant = imem_req;
        dmem_grant = dmem_req;
      end
    end
  end

  assign accept       = imem_grant | dmem_grant;
  assign imem_req_ack = imem_grant;
  assign dmem_req_ack = dmem_grant;

  always_comb begin
    case (dmem_width)
      SCR1_MEM_WIDTH_BYTE:  dmem_align_err = 1'b0;
      SCR1_MEM_WIDTH_HWORD: dmem_align_err = dmem_addr[0];
      default:              dmem_align_err = |dmem_addr[1:0];
    endcase
  end

  assign imem_err = SCR1_TCM_ERR_EN & (((imem_addr >> TCM_AW) != '0) | (|imem_addr[1:0]));
  assign dmem_err = SCR1_TCM_ERR_EN & (((dmem_addr >> TCM_AW) != '0) | dmem_align_err);

  // Errored stores must never reach the array, otherwise an out-of-range
  // address would alias onto a low word.
  assign dmem_write = dmem_grant & (dmem_cmd == SCR1_MEM_CMD_WR) & ~dmem_err;
  assign mem_addr   = dmem_grant ? dmem_addr[TCM_AW-1:2] : imem_addr[TCM_AW-1:2];
  assign mem_we     = dmem_write ? tcm_byte_en(dmem_width, dmem_addr[1:0]) : 4'b0000;
  assign mem_wdata  = tcm_wdata_rep(dmem_width, dmem_wdata);

  scr1_sp_memory #(
    .DEPTH (WORDS),
    .AW    (WAW)
  ) u_mem (
    .clk   (clk),
    .en    (accept),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  always_comb begin
    entry_next        = '0;
    entry_next.valid  = accept;
    entry_next.port   = dmem_grant ? TCM_PORT_DMEM : TCM_PORT_IMEM;
    entry_next.err    = dmem_grant ? dmem_err : imem_err;
    entry_next.offset = dmem_grant ? dmem_addr[1:0] : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SCR1_TCM_LATENCY; i++) begin
        pipe_reg[i] <= '0;
      end
      last_grant_reg <= TCM_PORT_IMEM;
    end else begin
      pipe_reg[0] <= entry_next;
      for (int i = 1; i < SCR1_TCM_LATENCY; i++) begin
        pipe_reg[i] <= pipe_reg[i-1];
      end
      if (accept) begin
        last_grant_reg <= entry_next.port;
      end
    end
  end

  // The RAM output register is the first latency stage; deeper latencies
  // delay its word alongside the matching pipeline entry.
  generate
    if (SCR1_TCM_LATENCY == 1) begin : g_data_lat1
      assign resp_data = mem_rdata;
    end else begin : g_data_latn
      logic [31:0] dly_reg [SCR1_TCM_LATENCY-1];
      always_ff @(posedge clk) begin
        dly_reg[0] <= mem_rdata;
        for (int i = 1; i < SCR1_TCM_LATENCY - 1; i++) begin
          dly_reg[i] <= dly_reg[i-1];
        end
      end
      assign resp_data = dly_reg[SCR1_TCM_LATENCY-2];
    end
  endgenerate

  assign head = pipe_reg[SCR1_TCM_LATENCY-1];

  always_comb begin
    imem_resp  = SCR1_MEM_RESP_NOTRDY;
    dmem_resp  = SCR1_MEM_RESP_NOTRDY;
    imem_rdata = '0;
    dmem_rdata = '0;
    if (rst_n && head.valid) begin
      if (head.port == TCM_PORT_IMEM) begin
        imem_resp = head.err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
        if (!head.err) begin
          imem_rdata = resp_data;
        end
      end else begin
        dmem_resp = head.err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
        if (!head.err) begin
          dmem_rdata = resp_data >> {head.offset, 3'b000};
        end
      end
    end
  end

endmodule

// File: tb/tb_scr1_tcm_sp.sv
// Scoreboard bench: two TCM instances (latency 2 and 4) share one stimulus
// stream; a negedge monitor matches every response against queued expectations.
module tb_scr1_tcm_sp;
  import scr1_memif_pkg::*;

  localparam logic [31:0] SIZE = 32'h0000_0400;

  localparam type_scr1_mem_resp_e  NR = SCR1_MEM_RESP_NOTRDY;
  localparam type_scr1_mem_resp_e  OK = SCR1_MEM_RESP_RDY_OK;
  localparam type_scr1_mem_resp_e  ER = SCR1_MEM_RESP_RDY_ER;
  localparam type_scr1_mem_cmd_e   RD = SCR1_MEM_CMD_RD;
  localparam type_scr1_mem_cmd_e   WR = SCR1_MEM_CMD_WR;
  localparam type_scr1_mem_width_e BY = SCR1_MEM_WIDTH_BYTE;
  localparam type_scr1_mem_width_e HW = SCR1_MEM_WIDTH_HWORD;
  localparam type_scr1_mem_width_e WD = SCR1_MEM_WIDTH_WORD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                 imem_req = 1'b0;
  logic [31:0]          imem_addr = '0;
  logic                 dmem_req = 1'b0;
  type_scr1_mem_cmd_e   dmem_cmd = SCR1_MEM_CMD_RD;
  type_scr1_mem_width_e dmem_width = SCR1_MEM_WIDTH_WORD;
  logic [31:0]          dmem_addr = '0;
  logic [31:0]          dmem_wdata = '0;

  logic i_ack2, d_ack2, i_ack4, d_ack4;
  logic [31:0] i_rdata2, d_rdata2, i_rdata4, d_rdata4;
  type_scr1_mem_resp_e i_resp2, d_resp2, i_resp4, d_resp4;

  scr1_tcm_sp #(.SCR1_TCM_SIZE(SIZE), .SCR1_TCM_LATENCY(2), .SCR1_TCM_ERR_EN(1'b1)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_req_ack(i_ack2), .imem_addr(imem_addr),
    .imem_rdata(i_rdata2), .imem_resp(i_resp2),
    .dmem_req(dmem_req), .dmem_req_ack(d_ack2), .dmem_cmd(dmem_cmd), .dmem_width(dmem_width),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(d_rdata2), .dmem_resp(d_resp2)
  );

  scr1_tcm_sp #(.SCR1_TCM_SIZE(SIZE), .SCR1_TCM_LATENCY(4), .SCR1_TCM_ERR_EN(1'b1)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_req_ack(i_ack4), .imem_addr(imem_addr),
    .imem_rdata(i_rdata4), .imem_resp(i_resp4),
    .dmem_req(dmem_req), .dmem_req_ack(d_ack4), .dmem_cmd(dmem_cmd), .dmem_width(dmem_width),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(d_rdata4), .dmem_resp(d_resp4)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // chan: 0 imem/lat2, 1 dmem/lat2, 2 imem/lat4, 3 dmem/lat4
  typedef struct {
    int                  chan;
    int                  due;
    type_scr1_mem_resp_e resp;
    logic [31:0]         data;
    bit                  chk;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic void push(input int ch, input int due, input type_scr1_mem_resp_e r,
                               input logic [31:0] d, input bit chk);
    exp_t e;
    e.chan = ch; e.due = due; e.resp = r; e.data = d; e.chk = chk;
    exp_q.push_back(e);
  endfunction

  function automatic void chk_ack(input string nm, input logic act, input bit exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: ack=%0b, expected %0b", nm, cyc, act, exp);
    end
  endfunction

  // Monitor: one comparison per channel per cycle.
  always @(negedge clk) begin
    type_scr1_mem_resp_e r;
    logic [31:0] d;
    int hit;
    for (int ch = 0; ch < 4; ch++) begin
      case (ch)
        0:       begin r = i_resp2; d = i_rdata2; end
        1:       begin r = d_resp2; d = d_rdata2; end
        2:       begin r = i_resp4; d = i_rdata4; end
        default: begin r = d_resp4; d = d_rdata4; end
      endcase
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i].chan == ch && exp_q[i].due < cyc) begin
          checks++;
          errors++;
          $display("FAIL missing ch=%0d due=%0d: no response seen, expected %s", ch, exp_q[i].due, exp_q[i].resp.name());
          exp_q.delete(i);
        end
      end
      hit = -1;
      for (int i = 0; i < exp_q.size(); i++) begin
        if (hit < 0 && exp_q[i].chan == ch && exp_q[i].due == cyc) hit = i;
      end
      checks++;
      if (hit >= 0) begin
        if (r !== exp_q[hit].resp || (exp_q[hit].chk && d !== exp_q[hit].data)) begin
          errors++;
          $display("FAIL resp ch=%0d cyc=%0d: got %s data=%h, expected %s data=%h",
                   ch, cyc, r.name(), d, exp_q[hit].resp.name(), exp_q[hit].data);
        end else begin
          $display("resp ch=%0d cyc=%0d %s data=%h", ch, cyc, r.name(), d);
        end
        exp_q.delete(hit);
      end else if (r !== NR || d !== 32'h0) begin
        errors++;
        $display("FAIL idle ch=%0d cyc=%0d: got %s data=%h, expected NOTRDY data=0", ch, cyc, r.name(), d);
      end
    end
  end

  task automatic xfer(input bit ireq, input logic [31:0] iaddr, input type_scr1_mem_resp_e iexp,
                      input logic [31:0] idata, input bit iack,
                      input bit dreq, input type_scr1_mem_cmd_e cmd, input type_scr1_mem_width_e w,
                      input logic [31:0] daddr, input logic [31:0] wd,
                      input type_scr1_mem_resp_e dexp, input logic [31:0] ddata, input bit dchk, input bit dack);
    @(negedge clk); #1;
    rst_n = 1'b1;
    imem_req = ireq; imem_addr = iaddr;
    dmem_req = dreq; dmem_cmd = cmd; dmem_width = w; dmem_addr = daddr; dmem_wdata = wd;
    #1;
    chk_ack("imem_ack_lat2", i_ack2, iack);
    chk_ack("dmem_ack_lat2", d_ack2, dack);
    chk_ack("imem_ack_lat4", i_ack4, iack);
    chk_ack("dmem_ack_lat4", d_ack4, dack);
    if (iack) begin
      push(0, cyc + 2, iexp, idata, 1'b1);
      push(2, cyc + 4, iexp, idata, 1'b1);
    end
    if (dack) begin
      push(1, cyc + 2, dexp, ddata, dchk);
      push(3, cyc + 4, dexp, ddata, dchk);
    end
    $display("xfer cyc=%0d imem req=%0b addr=%h | dmem req=%0b %s %s addr=%h wdata=%h",
             cyc, ireq, iaddr, dreq, cmd.name(), w.name(), daddr, wd);
  endtask

  task automatic dm(input type_scr1_mem_cmd_e cmd, input type_scr1_mem_width_e w, input logic [31:0] a,
                    input logic [31:0] wd, input type_scr1_mem_resp_e r, input logic [31:0] d, input bit chk);
    xfer(1'b0, 32'h0, NR, 32'h0, 1'b0, 1'b1, cmd, w, a, wd, r, d, chk, 1'b1);
  endtask

  task automatic im(input logic [31:0] a, input type_scr1_mem_resp_e r, input logic [31:0] d);
    xfer(1'b1, a, r, d, 1'b1, 1'b0, RD, WD, 32'h0, 32'h0, NR, 32'h0, 1'b0, 1'b0);
  endtask

  // Requests stay asserted through reset; nothing may be accepted and every
  // access still in flight is discarded.
  task automatic reset_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk); #1;
      rst_n = 1'b0;
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i].due > cyc) exp_q.delete(i);
      end
      imem_req = 1'b1; imem_addr = 32'h0;
      dmem_req = 1'b1; dmem_cmd = WR; dmem_width = WD; dmem_addr = 32'h0; dmem_wdata = 32'hFFFF_FFFF;
      #1;
      chk_ack("imem_ack_rst_lat2", i_ack2, 1'b0);
      chk_ack("dmem_ack_rst_lat2", d_ack2, 1'b0);
      chk_ack("imem_ack_rst_lat4", i_ack4, 1'b0);
      chk_ack("dmem_ack_rst_lat4", d_ack4, 1'b0);
      $display("reset cyc=%0d", cyc);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk); #1;
      rst_n = 1'b1;
      imem_req = 1'b0;
      dmem_req = 1'b0;
    end
  endtask

  initial begin
    reset_cycles(3);

    // Both ports contending: dmem, imem, dmem, imem, then dmem alone.
    xfer(1'b1, 32'h20, OK, 32'h0,         1'b0, 1'b1, WR, WD, 32'h20, 32'hCAFE0001, OK, 32'h0, 1'b0, 1'b1);
    xfer(1'b1, 32'h20, OK, 32'hCAFE0001,  1'b1, 1'b1, WR, WD, 32'h20, 32'hCAFE0002, OK, 32'h0, 1'b0, 1'b0);
    xfer(1'b1, 32'h20, OK, 32'h0,         1'b0, 1'b1, WR, WD, 32'h20, 32'hCAFE0002, OK, 32'h0, 1'b0, 1'b1);
    xfer(1'b1, 32'h20, OK, 32'hCAFE0002,  1'b1, 1'b1, WR, WD, 32'h24, 32'hCAFE0003, OK, 32'h0, 1'b0, 1'b0);
    xfer(1'b0, 32'h0,  NR, 32'h0,         1'b0, 1'b1, WR, WD, 32'h24, 32'hCAFE0003, OK, 32'h0, 1'b0, 1'b1);
    im(32'h24, OK, 32'hCAFE0003);

    // Sub-word stores and offset-shifted loads.
    dm(WR, BY, 32'h3, 32'h0000_00A5, OK, 32'h0,         1'b0);
    dm(RD, WD, 32'h0, 32'h0,         OK, 32'hA500_0000, 1'b1);
    dm(RD, BY, 32'h3, 32'h0,         OK, 32'h0000_00A5, 1'b1);
    dm(RD, HW, 32'h2, 32'h0,         OK, 32'h0000_A500, 1'b1);
    dm(WR, HW, 32'h6, 32'h0000_BEEF, OK, 32'h0,         1'b0);
    dm(RD, WD, 32'h4, 32'h0,         OK, 32'hBEEF_0000, 1'b1);

    // Misaligned accesses error out and leave memory untouched.
    dm(RD, HW, 32'h1, 32'h0,         ER, 32'h0,         1'b1);
    im(32'h2, ER, 32'h0);
    dm(WR, WD, 32'h2, 32'hFFFF_FFFF, ER, 32'h0,         1'b1);
    dm(RD, WD, 32'h0, 32'h0,         OK, 32'hA500_0000, 1'b1);

    // Top word is usable; one past the end errors without aliasing.
    dm(WR, WD, SIZE - 32'd4, 32'hDEAD_BEEF, OK, 32'h0,         1'b0);
    dm(RD, WD, SIZE - 32'd4, 32'h0,         OK, 32'hDEAD_BEEF, 1'b1);
    dm(WR, WD, SIZE,         32'h5555_5555, ER, 32'h0,         1'b1);
    dm(RD, WD, SIZE,         32'h0,         ER, 32'h0,         1'b1);
    dm(RD, WD, 32'h0,        32'h0,         OK, 32'hA500_0000, 1'b1);
    im(SIZE, ER, 32'h0);
    im(SIZE - 32'd4, OK, 32'hDEAD_BEEF);

    // Back-to-back store then load of the same word.
    dm(WR, WD, 32'h40, 32'h1234_5678, OK, 32'h0,         1'b0);
    dm(RD, WD, 32'h40, 32'h0,         OK, 32'h1234_5678, 1'b1);

    // Reset with three loads in flight, then a normal access afterwards.
    dm(RD, WD, 32'h40,       32'h0, OK, 32'h1234_5678, 1'b1);
    dm(RD, WD, SIZE - 32'd4, 32'h0, OK, 32'hDEAD_BEEF, 1'b1);
    dm(RD, WD, 32'h0,        32'h0, OK, 32'hA500_0000, 1'b1);
    reset_cycles(2);
    dm(RD, WD, 32'h40, 32'h0, OK, 32'h1234_5678, 1'b1);
    im(SIZE - 32'd4, OK, 32'hDEAD_BEEF);

    idle(8);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses still pending, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scr1_tcm_sp.md
SCR1_TCM_SP -- requirements
Module: scr1_tcm_sp

Interface
REQ-001 Parameter SCR1_TCM_SIZE, default `SCR1_IMEM_AWIDTH'h00010000, TCM bytes; power of two, at least 16.
REQ-002 Parameter SCR1_TCM_LATENCY, default 1, cycles from accept to response; legal range 1..4.
REQ-003 Parameter SCR1_TCM_ERR_EN, default 1, enables the range and alignment error checks.
REQ-004 clk  input  1  single clock; all logic on posedge.
REQ-005 rst_n  input  1  synchronous, active-low reset, sampled on posedge clk.
REQ-006 imem_req  input  1  instruction fetch request.
REQ-007 imem_req_ack  output  1  fetch accepted this cycle.
REQ-008 imem_addr  input  `SCR1_IMEM_AWIDTH  fetch byte address.
REQ-009 imem_rdata  output  32  fetch data; valid when imem_resp is RDY_OK.
REQ-010 imem_resp  output  type_scr1_mem_resp_e  fetch response.
REQ-011 dmem_req  input  1  data request.
REQ-012 dmem_req_ack  output  1  data request accepted this cycle.
REQ-013 dmem_cmd  input  type_scr1_mem_cmd_e  RD or WR.
REQ-014 dmem_width  input  type_scr1_mem_width_e  BYTE, HWORD or WORD.
REQ-015 dmem_addr  input  32  data byte address.
REQ-016 dmem_wdata  input  32  write data, LSB-aligned.
REQ-017 dmem_rdata  output  32  read data, right-shifted by the byte offset.
REQ-018 dmem_resp  output  type_scr1_mem_resp_e  data response.

Function
REQ-019 The block SHALL use one single-port 32-bit memory shared by both ports, so at most one access is accepted per cycle.
REQ-020 Arbitration SHALL be combinational: the sole requester is granted; if both request, grant goes to the port not granted last; last_grant resets to imem, so dmem wins the first tie.
REQ-021 The granted port's req_ack SHALL be 1 in the accept cycle; the losing port's req_ack SHALL be 0, and that port holds its request.
REQ-022 Each accepted access SHALL enter a SCR1_TCM_LATENCY-deep pipeline carrying {valid, port, err, byte offset}; no stalls, so throughput is 1 per cycle.
REQ-023 Response SHALL appear exactly SCR1_TCM_LATENCY cycles after acceptance, as a single-cycle RDY_OK or RDY_ER on the owning port; otherwise the response is NOTRDY.
REQ-024 When that port's resp is not RDY_OK, rdata SHALL be 0.
REQ-025 Range error (when ERR_EN=1): any address bit at or above $clog2(SCR1_TCM_SIZE) set -> RDY_ER.
REQ-026 Alignment error (when ERR_EN=1): imem addr[1:0]!=0; dmem HWORD addr[0]=1; dmem WORD addr[1:0]!=0 -> RDY_ER.
REQ-027 An errored access SHALL perform no memory write, and its read data SHALL be 0.
REQ-028 Writes: byte lanes are replicated; byte enable = 0001<<addr[1:0] for BYTE, 0011<<{addr[1],0} for HWORD, 1111 for WORD.
REQ-029 Writes take effect at the accept edge and still return RDY_OK after the latency.
REQ-030 Read-after-write to the same word, accepted back-to-back, SHALL return the new data.
REQ-031 The last address word SHALL be accessible; there is no wrap-around, and addresses beyond the size are errors per REQ-025.

Reset
REQ-032 While rst_n=0 at a clock edge, the block SHALL drive imem_resp=dmem_resp=NOTRDY, clear all pipeline valids, set last_grant=imem, and suppress all writes.
REQ-033 During reset, req_ack SHALL be 0 and rdata SHALL be 0.
REQ-034 A reset mid-operation SHALL discard in-flight accesses with no response; memory contents are not cleared.

Structure
REQ-035 Pipeline-entry struct and port-id enum SHALL live in a shared package, scr1_tcm_pkg; the memory type enums remain in the existing memif header.
REQ-036 Storage SHALL be a sub-module, scr1_sp_memory (one read/write port, byte write enables, 1-cycle registered read); extra latency stages sit in scr1_tcm_sp.

Verification
REQ-037 Both ports request every cycle, LATENCY=2: grants alternate dmem, imem, dmem...; each response arrives 2 cycles after its ack.
REQ-038 Byte write 0xA5 at 0x3, then word read at 0x0 from zero-initialised memory -> RDY_OK, dmem_rdata=0xA5000000.
REQ-039 HWORD read at 0x1 and imem fetch at 0x2 -> RDY_ER on both, rdata 0, memory unchanged.
REQ-040 Address SCR1_TCM_SIZE-4 WORD write/read -> OK with data intact; address SCR1_TCM_SIZE -> RDY_ER, no aliasing write at 0x0.
REQ-041 Assert rst_n=0 with 3 accesses in flight (LATENCY=4) -> no responses, then after release a first access completes normally.
REQ-042 Back-to-back write 0x12345678 then read at 0x40 -> read returns 0x12345678.
